// File: rtl/palette_fade_lut_if.sv
// palette_fade_lut_if: pixel lookup, palette write and fade control bundle
// master drives index/write/fade requests; slave returns scaled colour and fade status
interface palette_fade_lut_if #(
  parameter int INDEX_W = 4,
  parameter int COLOR_W = 4
);
  logic                   pix_valid;
  logic [INDEX_W-1:0]     index;
  logic                   wr_en;
  logic [INDEX_W-1:0]     wr_addr;
  logic [3*COLOR_W-1:0]   wr_data;
  logic                   fade_out_start;
  logic                   fade_in_start;
  logic [COLOR_W-1:0]     red;
  logic [COLOR_W-1:0]     green;
  logic [COLOR_W-1:0]     blue;
  logic                   rgb_valid;
  logic                   fade_busy;
  logic                   fade_done;
  modport master (
    output pix_valid, index, wr_en, wr_addr, wr_data, fade_out_start, fade_in_start,
    input  red, green, blue, rgb_valid, fade_busy, fade_done
  );
  modport slave (
    input  pix_valid, index, wr_en, wr_addr, wr_data, fade_out_start, fade_in_start,
    output red, green, blue, rgb_valid, fade_busy, fade_done
  );
endinterface

// File: rtl/palette_fade_lut.sv
// palette_fade_lut: writable RGB palette with 2-stage lookup and global brightness fader
// ports: clk, reset (async, active-high), b (slave): pix_valid/index lookup in,
// wr_en/wr_addr/wr_data palette write, fade_out_start/fade_in_start requests,
// red/green/blue/rgb_valid scaled colour out, fade_busy/fade_done fade status
module palette_fade_lut #(
  parameter int INDEX_W  = 4,
  parameter int COLOR_W  = 4,
  parameter int LVL_W    = 4,
  parameter int STEP_DIV = 65536
) (
  input logic               clk,
  input logic               reset,
  palette_fade_lut_if.slave b
);
  localparam int DEPTH = 1 << INDEX_W;
  localparam int CNT_W = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam logic [LVL_W:0] LVL_MAX = (LVL_W+1)'(1 << LVL_W);
  typedef enum logic [1:0] {FULL, FADE_OUT, BLACK, FADE_IN} state_t;
  state_t               state_q, state_d;
  logic [LVL_W:0]       level_q, level_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_d;
  logic                 step;
  logic [3*COLOR_W-1:0] pal [DEPTH];
  logic [3*COLOR_W-1:0] s1_rgb;
  logic                 s1_v;
  // evenly spaced gray ramp from black to full white across the palette
  function automatic logic [COLOR_W-1:0] gray(int i);
    return COLOR_W'((i * ((1 << COLOR_W) - 1)) / ((1 << INDEX_W) - 1));
  endfunction
  // product is one bit wider than c+level so level = 2^LVL_W passes c unchanged
  function automatic logic [COLOR_W-1:0] scale(logic [COLOR_W-1:0] c, logic [LVL_W:0] l);
    logic [COLOR_W+LVL_W:0] p;
    p = {{(LVL_W+1){1'b0}}, c} * {{COLOR_W{1'b0}}, l};
    return COLOR_W'(p >> LVL_W);
  endfunction
  assign step = cnt_q == CNT_W'(STEP_DIV - 1);
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      FULL: if (b.fade_out_start) begin
        state_d = FADE_OUT;
        cnt_d   = '0;
      end
      BLACK: if (b.fade_in_start && !b.fade_out_start) begin
        state_d = FADE_IN;
        cnt_d   = '0;
      end
      FADE_OUT: if (b.fade_in_start && !b.fade_out_start) begin
        state_d = FADE_IN;
        cnt_d   = '0;
      end else if (step) begin
        cnt_d   = '0;
        level_d = level_q - 1'b1;
        state_d = level_q == 1 ? BLACK : FADE_OUT;
        done_d  = level_q == 1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      FADE_IN: if (b.fade_out_start) begin
        state_d = FADE_OUT;
        cnt_d   = '0;
      end else if (step) begin
        cnt_d   = '0;
        level_d = level_q + 1'b1;
        state_d = level_q == LVL_MAX - 1'b1 ? FULL : FADE_IN;
        done_d  = level_q == LVL_MAX - 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = FULL;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FULL;
      level_q     <= LVL_MAX;
      cnt_q       <= '0;
      b.fade_busy <= 1'b0;
      b.fade_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      b.fade_busy <= state_d == FADE_OUT || state_d == FADE_IN;
      b.fade_done <= done_d;
    end
  end
  // read before write: a same-edge lookup of the entry being written sees old data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pal[i] <= {3{gray(i)}};
      s1_rgb      <= '0;
      s1_v        <= 1'b0;
      b.red       <= '0;
      b.green     <= '0;
      b.blue      <= '0;
      b.rgb_valid <= 1'b0;
    end else begin
      if (b.wr_en) pal[b.wr_addr] <= b.wr_data;
      s1_rgb      <= pal[b.index];
      s1_v        <= b.pix_valid;
      b.red       <= scale(s1_rgb[3*COLOR_W-1:2*COLOR_W], level_q);
      b.green     <= scale(s1_rgb[2*COLOR_W-1:COLOR_W], level_q);
      b.blue      <= scale(s1_rgb[COLOR_W-1:0], level_q);
      b.rgb_valid <= s1_v;
    end
  end
endmodule

// File: tb/tb_palette_fade_lut.sv
// tb_palette_fade_lut: scoreboarded lookup checks plus cycle-exact fade timing checks
module tb_palette_fade_lut;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [11:0] q[$];
  always #5 clk = ~clk;
  palette_fade_lut_if #(.INDEX_W(4), .COLOR_W(4)) b();
  palette_fade_lut #(.INDEX_W(4), .COLOR_W(4), .LVL_W(4), .STEP_DIV(2)) dut (
    .clk(clk), .reset(reset), .b(b)
  );
  function automatic logic [11:0] scl(logic [11:0] c, int l);
    int r, g, bl;
    r  = int'(c[11:8]) * l / 16;
    g  = int'(c[7:4]) * l / 16;
    bl = int'(c[3:0]) * l / 16;
    return {4'(r), 4'(g), 4'(bl)};
  endfunction
  function automatic int lvl_out(int j);
    if (j < 0) return 16;
    return (16 - j / 2) < 0 ? 0 : 16 - j / 2;
  endfunction
  function automatic int lvl_in(int j);
    if (j < 0) return 0;
    return (j / 2) > 16 ? 16 : j / 2;
  endfunction
  function automatic int lvl_rev(int j);
    if (j <= 20) return lvl_out(j);
    return (6 + (j - 21) / 2) > 16 ? 16 : 6 + (j - 21) / 2;
  endfunction
  always @(negedge clk) begin : mon
    logic [11:0] e;
    if (!reset && b.rgb_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow got %h want none", {b.red, b.green, b.blue});
      end else begin
        e = q.pop_front();
        if ({b.red, b.green, b.blue} !== e) begin
          errors++;
          $display("FAIL lookup got %h want %h", {b.red, b.green, b.blue}, e);
        end
      end
    end
  end
  task automatic test_reset();
    #12;
    checks++; if ({b.red, b.green, b.blue} !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h want 000", {b.red, b.green, b.blue}); end
    checks++; if (b.rgb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", b.rgb_valid); end
    checks++; if (b.fade_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", b.fade_busy); end
    checks++; if (b.fade_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", b.fade_done); end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic drain(string name);
    b.pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL %s_pending got %0d want 0", name, q.size()); end
  endtask
  task automatic test_sweep();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++; if (b.rgb_valid !== 1'b0) begin errors++; $display("FAIL valid_lat1 got %b want 0", b.rgb_valid); end
      end
      if (i == 2) begin
        checks++; if (b.rgb_valid !== 1'b1) begin errors++; $display("FAIL valid_lat2 got %b want 1", b.rgb_valid); end
      end
      b.pix_valid = 1'b1;
      b.index = 4'(i);
      q.push_back({3{4'(i)}});
    end
    @(negedge clk);
    drain("sweep");
  endtask
  task automatic test_write();
    @(negedge clk);
    b.wr_en = 1'b1; b.wr_addr = 4'd5; b.wr_data = 12'hF80;
    b.pix_valid = 1'b1; b.index = 4'd5;
    q.push_back(12'h555);
    @(negedge clk);
    b.wr_en = 1'b0;
    q.push_back(12'hF80);
    @(negedge clk);
    drain("write");
  endtask
  task automatic test_fade_out();
    int dones = 0;
    @(negedge clk);
    b.wr_en = 1'b1; b.wr_addr = 4'd3; b.wr_data = 12'hF80; b.index = 4'd3;
    @(negedge clk);
    b.wr_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({b.red, b.green, b.blue} !== 12'hF80) begin errors++; $display("FAIL fo_pre got %h want F80", {b.red, b.green, b.blue}); end
    b.fade_out_start = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (k == 0) b.fade_out_start = 1'b0;
      if (b.fade_done === 1'b1) dones++;
      checks++; if ({b.red, b.green, b.blue} !== scl(12'hF80, lvl_out(k - 1))) begin errors++; $display("FAIL fo_rgb k=%0d got %h want %h", k, {b.red, b.green, b.blue}, scl(12'hF80, lvl_out(k - 1))); end
      checks++; if (b.fade_busy !== (k < 32)) begin errors++; $display("FAIL fo_busy k=%0d got %b want %b", k, b.fade_busy, k < 32); end
      checks++; if (b.fade_done !== (k == 32)) begin errors++; $display("FAIL fo_done k=%0d got %b want %b", k, b.fade_done, k == 32); end
      if (k == 17) begin
        checks++; if ({b.red, b.green, b.blue} !== 12'h740) begin errors++; $display("FAIL fo_half got %h want 740", {b.red, b.green, b.blue}); end
      end
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL fo_pulses got %0d want 1", dones); end
    checks++; if ({b.red, b.green, b.blue} !== 12'h000) begin errors++; $display("FAIL fo_black got %h want 000", {b.red, b.green, b.blue}); end
  endtask
  task automatic test_fade_in();
    @(negedge clk);
    b.fade_in_start = 1'b1;
    for (int k = 0; k <= 35; k++) begin
      @(negedge clk);
      if (k == 0) b.fade_in_start = 1'b0;
      checks++; if ({b.red, b.green, b.blue} !== scl(12'hF80, lvl_in(k - 1))) begin errors++; $display("FAIL fi_rgb k=%0d got %h want %h", k, {b.red, b.green, b.blue}, scl(12'hF80, lvl_in(k - 1))); end
      checks++; if (b.fade_done !== (k == 32)) begin errors++; $display("FAIL fi_done k=%0d got %b want %b", k, b.fade_done, k == 32); end
    end
    checks++; if ({b.red, b.green, b.blue} !== 12'hF80) begin errors++; $display("FAIL fi_full got %h want F80", {b.red, b.green, b.blue}); end
  endtask
  task automatic test_reverse();
    int dones = 0;
    @(negedge clk);
    b.fade_out_start = 1'b1;
    for (int k = 0; k <= 45; k++) begin
      @(negedge clk);
      if (k == 0) b.fade_out_start = 1'b0;
      if (k == 20) b.fade_in_start = 1'b1;
      if (k == 21) b.fade_in_start = 1'b0;
      if (b.fade_done === 1'b1) dones++;
      checks++; if ({b.red, b.green, b.blue} !== scl(12'hF80, lvl_rev(k - 1))) begin errors++; $display("FAIL rev_rgb k=%0d got %h want %h", k, {b.red, b.green, b.blue}, scl(12'hF80, lvl_rev(k - 1))); end
      checks++; if (b.fade_busy !== (k < 41)) begin errors++; $display("FAIL rev_busy k=%0d got %b want %b", k, b.fade_busy, k < 41); end
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL rev_pulses got %0d want 1", dones); end
  endtask
  task automatic test_both();
    @(negedge clk);
    b.fade_in_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      b.fade_in_start = 1'b0;
      checks++; if (b.fade_busy !== 1'b0) begin errors++; $display("FAIL full_ignore k=%0d got %b want 0", k, b.fade_busy); end
    end
    b.fade_out_start = 1'b1;
    b.fade_in_start = 1'b1;
    @(negedge clk);
    b.fade_out_start = 1'b0;
    b.fade_in_start = 1'b0;
    checks++; if (b.fade_busy !== 1'b1) begin errors++; $display("FAIL both_busy got %b want 1", b.fade_busy); end
    repeat (3) @(negedge clk);
    checks++; if ({b.red, b.green, b.blue} !== 12'hE70) begin errors++; $display("FAIL both_dir got %h want E70", {b.red, b.green, b.blue}); end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    while (b.fade_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++; if (b.fade_done !== 1'b1) begin errors++; $display("FAIL wait_black got %b want 1", b.fade_done); end
    b.fade_in_start = 1'b1;
    @(negedge clk);
    b.fade_in_start = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (b.fade_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", b.fade_busy); end
    b.wr_en = 1'b1; b.wr_addr = 4'd7; b.wr_data = 12'h123;
    #2 reset = 1'b1;
    #1;
    checks++; if ({b.red, b.green, b.blue} !== 12'h000) begin errors++; $display("FAIL arst_rgb got %h want 000", {b.red, b.green, b.blue}); end
    checks++; if (b.fade_busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", b.fade_busy); end
    checks++; if (b.rgb_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", b.rgb_valid); end
    @(negedge clk);
    reset = 1'b0;
    b.wr_en = 1'b0;
    b.pix_valid = 1'b1;
    b.index = 4'd3; q.push_back(12'h333);
    @(negedge clk);
    b.index = 4'd5; q.push_back(12'h555);
    @(negedge clk);
    b.index = 4'd7; q.push_back(12'h777);
    @(negedge clk);
    drain("arst");
  endtask
  initial begin
    b.pix_valid = 1'b0; b.index = '0; b.wr_en = 1'b0; b.wr_addr = '0; b.wr_data = '0;
    b.fade_out_start = 1'b0; b.fade_in_start = 1'b0;
    test_reset();
    test_sweep();
    test_write();
    test_fade_out();
    test_fade_in();
    test_reverse();
    test_both();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
